pool_row_merger: RTL
====================

// Module: pool_row_merger
// PURPOSE
//   Read side of the 2x2 max-pool row buffer. Once a full row A of horizontal maxima is stored, the
//   block takes the row-B horizontal maxima stream, reads the matching row-A word from the buffer,
//   and emits max(A,B) downstream with valid/ready. It sits between the pool row buffer and the pool output/requant stage.
// PARAMETERS
//   DATA_WIDTH  16   signed two's-complement pixel width
//   ROW_LEN     10   words per pooled row; must equal the row buffer's FIFO_SIZE
//   CNT_WIDTH   4    counter width, must hold ROW_LEN (2**CNT_WIDTH > ROW_LEN)
// PORTS
//   clk           in   1           clock, rising edge
//   rst_n         in   1           reset, asynchronous, active-low
//   row_full      in   1           row buffer full flag; single-cycle pulse per completed row A
//   buf_rd_en     out  1           read strobe to row buffer
//   buf_rdata     in   DATA_WIDTH  row buffer read data, valid exactly 1 cycle after buf_rd_en
//   s_valid       in   1           row-B pixel valid
//   s_ready       out  1           row-B pixel accepted when s_valid&&s_ready
//   s_data        in   DATA_WIDTH  row-B pixel
//   m_valid       out  1           pooled output valid
//   m_ready       in   1           downstream ready
//   m_data        out  DATA_WIDTH  pooled output = signed max(A,B)
//   m_last        out  1           high with the ROW_LEN-th output of a row
//   busy          out  1           state != IDLE
//   overflow_err  out  1           sticky: row_full seen while one row already pending
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; counters, pending flag, skid FIFO cleared. Reset mid-row
//     drops all in-flight data; no partial output after rst_n deasserts.
//   - row_full latched into row_pending (1 deep). Pulse while row_pending=1 and not consumed same
//     cycle -> overflow_err<=1 (cleared only by reset); pulse dropped.
//   - FSM: IDLE -> MERGE when row_pending (clears it, in_cnt<=0).
//     MERGE -> DRAIN on the accept that makes in_cnt==ROW_LEN.
//     DRAIN -> MERGE if row_pending when last output pops, else -> IDLE; both require s1 empty and skid empty.
//   - Accept: s_ready = MERGE && in_cnt<ROW_LEN && (occ + s1_valid - pop) <= 1, where occ = skid
//     occupancy (0..2), pop = m_valid&&m_ready (combinational path from m_ready is intended).
//   - buf_rd_en = s_valid && s_ready (same cycle). s_data captured into stage s1.
//   - Next cycle s1 combines with buf_rdata: max computed signed, written to 2-entry skid FIFO with last
//     flag = (element index == ROW_LEN-1). s1 always advances; the accept rule guarantees room.
//   - Latency: accept at t -> m_valid at t+2 when skid empty. Throughput 1/cycle with m_ready=1.
//   - m_data/m_last/m_valid driven from skid head; stable while m_valid && !m_ready.
//   - Simultaneous row_full and IDLE->MERGE consumption: pending ends set (new row counts).
//   - buf_rd_en never asserted outside MERGE; exactly ROW_LEN reads per row.
// CONFIGURATION
//   POOL_RELU_EN defined: m_data = (max < 0) ? 0 : max (fused ReLU).
//   Not defined: m_data = raw signed max, negatives passed through.
// STRUCTURE
//   Shared package pool_pkg: state enum {IDLE,MERGE,DRAIN}, default DATA_WIDTH/ROW_LEN constants,
//   function pool_smax(a,b) signed max.
//   Sub-module: pool_skid_fifo (2-entry, DATA_WIDTH+1 wide, push/pop/occ); rest inline.
// TESTING
//   1 Reset, row_full pulse, 10 B pixels with m_ready=1, A=0..9, B=9..0 -> out 9,8,7,6,5,5,6,7,8,9, m_last on 10th, busy drops.
//   2 Signed: A=-5,B=-3 -> m_data=-3; with POOL_RELU_EN -> 0; A=0x8000,B=0x7FFF -> 0x7FFF.
//   3 Backpressure: m_ready toggles 1/0 every 2 cycles -> no loss/duplication, 10 outputs in order,
//     buf_rd_en count=10, s_ready low whenever skid+s1 would exceed 2.
//   4 Back-to-back rows: second row_full pulse during DRAIN -> goes straight to MERGE, 20 outputs,
//     two m_last; third pulse while pending -> overflow_err=1 and stays.
//   5 s_valid held low mid-row 5 cycles -> no buf_rd_en, no output gap corruption, in_cnt resumes.
//   6 rst_n asserted after 4 accepts -> outputs 0 immediately; after release, fresh row yields exactly 10 outputs.

Source files
------------

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, default sizes and signed-max helper for the pool row merger
package pool_pkg;

    localparam int POOL_DATA_WIDTH = 16;
    localparam int POOL_ROW_LEN    = 10;
    localparam int POOL_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        DRAIN = 2'd2
    } pool_state_t;

    // Signed max on sign-extended operands so any pixel width up to 32 bits fits.
    function automatic logic signed [31:0] pool_smax(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_skid_fifo.sv
// rtl/pool_skid_fifo.sv - 2-entry output skid FIFO holding {last, pooled pixel}
module pool_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (occ != 2'd0);

endmodule

// File: rtl/pool_row_merger.sv
// rtl/pool_row_merger.sv - merges row-B maxima with buffered row A into 2x2 pooled output; POOL_RELU_EN fuses ReLU
module pool_row_merger
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int ROW_LEN    = POOL_ROW_LEN,
    parameter int CNT_WIDTH  = POOL_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_full,
    output logic                  buf_rd_en,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overflow_err
);

    localparam logic [CNT_WIDTH-1:0] ROW_LEN_C = CNT_WIDTH'(ROW_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(ROW_LEN - 1);

    pool_state_t           state;
    pool_state_t           state_nxt;
    logic                  row_pending;
    logic                  consume;
    logic [CNT_WIDTH-1:0]  in_cnt;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_last;

    logic [1:0]            occ;
    logic                  pop;
    logic                  accept;
    logic [2:0]            room_need;
    logic [2:0]            room_have;

    logic signed [31:0]    a_ext;
    logic signed [31:0]    b_ext;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH:0]   skid_head;
    logic                  skid_valid;

    assign pop = m_valid && m_ready;

    // Accept only if the skid FIFO can absorb everything already in flight plus this pixel.
    assign room_need = {1'b0, occ} + {2'b00, s1_valid};
    assign room_have = 3'd1 + {2'b00, pop};
    assign s_ready   = (state == MERGE) && (in_cnt < ROW_LEN_C) && (room_need <= room_have);
    assign accept    = s_valid && s_ready;
    assign buf_rd_en = accept;
    assign busy      = (state != IDLE);

    // Next-state logic; consume marks the cycle a pending row is taken.
    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (row_pending) begin
                    state_nxt = MERGE;
                    consume   = 1'b1;
                end
            end
            MERGE: begin
                if (accept && (in_cnt == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last && !s1_valid && (occ == 2'd1)) begin
                    if (row_pending) begin
                        state_nxt = MERGE;
                        consume   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, input counter, one-deep row-pending flag and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_cnt       <= '0;
            row_pending  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (consume) begin
                in_cnt <= '0;
            end else if (accept) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (consume) begin
                row_pending <= row_full;
            end else if (row_full) begin
                row_pending <= 1'b1;
            end
            if (row_full && row_pending && !consume) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Stage s1 holds the accepted row-B pixel while the buffer read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= s_data;
                s1_last <= (in_cnt == LAST_IDX);
            end
        end
    end

    // Signed max of row-A word and row-B pixel, optionally clamped at zero.
    always_comb begin
        a_ext  = 32'($signed(buf_rdata));
        b_ext  = 32'($signed(s1_data));
        merged = (pool_smax(a_ext, b_ext) == a_ext) ? buf_rdata : s1_data;
`ifdef POOL_RELU_EN
        if (merged[DATA_WIDTH-1]) begin
            merged = '0;
        end
`endif
    end

    pool_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (s1_valid),
        .push_data  ({s1_last, merged}),
        .pop        (pop),
        .head_data  (skid_head),
        .head_valid (skid_valid),
        .occ        (occ)
    );

    assign m_valid = skid_valid;
    assign m_last  = skid_head[DATA_WIDTH];
    assign m_data  = skid_head[DATA_WIDTH-1:0];

endmodule
